ram_port_ctrl: RTL

- Bus-side controller feeding port b (read/write port) of the core's dual-port instruction/data RAM.
- Accepts load/store requests from the core over a valid/ready channel and checks alignment and range.
- Generates the RAM address, byte-lane write strobes and replicated write data.
- Returns a lane-extracted, sign- or zero-extended response one cycle later, with full back-pressure support.

---
 rtl/ram_port_ctrl_pkg.sv | 11 +
 rtl/ram_port_ctrl_if.sv | 18 +
 rtl/ram_lane_fmt.sv | 23 ++
 rtl/ram_port_ctrl.sv | 67 ++++++
 4 files changed

// File: rtl/ram_port_ctrl_pkg.sv
// ram_port_ctrl_pkg: shared encodings and sizing helpers for the RAM port b controller
package ram_port_ctrl_pkg;
  localparam int DEF_DEPTH = 2048;
  function automatic int clogb2(input int v);
    int r = 0;
    for (int x = v; x > 0; x = x >> 1) r++;
    return r;
  endfunction
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11} size_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LIVE, ST_HELD} state_t;
endpackage

// File: rtl/ram_port_ctrl_if.sv
// ram_port_ctrl_if: core-side request/response channel of the RAM port b controller
interface ram_port_ctrl_if;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master(output req_vld, req_addr, req_wdata, req_we, req_size, req_unsigned, rsp_rdy,
                 input req_rdy, rsp_vld, rsp_rdata, rsp_err);
  modport slave(input req_vld, req_addr, req_wdata, req_we, req_size, req_unsigned, rsp_rdy,
                output req_rdy, rsp_vld, rsp_rdata, rsp_err);
endinterface

// File: rtl/ram_lane_fmt.sv
// ram_lane_fmt: byte-lane strobes/replication for stores and lane extract/extend for loads
module ram_lane_fmt
  import ram_port_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] dout,
  output logic [3:0]  wem,
  output logic [31:0] din,
  output logic [31:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = dout[{lo, 3'b000} +: 8];
  assign h = dout[{lo[1], 4'b0000} +: 16];
  always_comb begin
    wem   = size == SZ_B ? 4'b0001 << lo : size == SZ_H ? 4'b0011 << lo : 4'b1111;
    din   = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
    rdata = size == SZ_B ? {{24{!uns && b[7]}}, b} : size == SZ_H ? {{16{!uns && h[15]}}, h} : dout;
  end
endmodule

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: load/store controller for RAM port b with 1-cycle response and back-pressure hold
module ram_port_ctrl
  import ram_port_ctrl_pkg::*;
#(
  parameter int RAM_DEPTH = DEF_DEPTH,
  localparam int AW = clogb2(RAM_DEPTH - 1)
) (
  input  logic          clk,
  input  logic          rst,
  ram_port_ctrl_if.slave bus,
  output logic          ram_en,
  output logic          ram_we,
  output logic [3:0]    ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout
);
  state_t      state, nxt;
  logic        acc, err, r_we, r_uns, r_err;
  logic [1:0]  r_size, r_lo;
  logic [3:0]  st_wem, ld_unused_wem;
  logic [31:0] st_din, st_unused_rd, ld_unused_din, ld_rd, live, hold;
  assign err = bus.req_size == SZ_X || (bus.req_size == SZ_H && bus.req_addr[0]) ||
               (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00) ||
               {2'b00, bus.req_addr[31:2]} >= 32'(RAM_DEPTH);
  assign bus.rsp_vld = state != ST_IDLE;
  assign bus.req_rdy = !rst && (state == ST_IDLE || (bus.rsp_vld && bus.rsp_rdy));
  assign acc = bus.req_vld && bus.req_rdy;
  assign ram_en = acc && !err;
  assign ram_we = ram_en && bus.req_we;
  assign ram_wem = ram_we ? st_wem : 4'b0000;
  assign ram_addr = bus.req_addr[AW+1:2];
  assign ram_din = st_din;
  ram_lane_fmt st (
    .size(bus.req_size), .lo(bus.req_addr[1:0]), .uns(1'b0), .wdata(bus.req_wdata), .dout(32'h0),
    .wem(st_wem), .din(st_din), .rdata(st_unused_rd)
  );
  ram_lane_fmt ld (
    .size(r_size), .lo(r_lo), .uns(r_uns), .wdata(32'h0), .dout(ram_dout),
    .wem(ld_unused_wem), .din(ld_unused_din), .rdata(ld_rd)
  );
  assign live = (r_we || r_err) ? 32'h0 : ld_rd;
  assign bus.rsp_rdata = state == ST_HELD ? hold : state == ST_LIVE ? live : 32'h0;
  assign bus.rsp_err = bus.rsp_vld && r_err;
  always_comb nxt = acc ? ST_LIVE : (state == ST_IDLE || bus.rsp_rdy) ? ST_IDLE : ST_HELD;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      r_we   <= 1'b0;
      r_uns  <= 1'b0;
      r_err  <= 1'b0;
      r_size <= 2'b00;
      r_lo   <= 2'b00;
      hold   <= 32'h0;
    end else begin
      state <= nxt;
      if (acc) begin
        r_we   <= bus.req_we;
        r_uns  <= bus.req_unsigned;
        r_err  <= err;
        r_size <= bus.req_size;
        r_lo   <= bus.req_addr[1:0];
      end
      if (state == ST_LIVE && !bus.rsp_rdy) hold <= live;
    end
  end
endmodule
